// File: rtl/banked_regfile_pkg.sv
// Shared constants and types for the banked register file.
// No ports: imported by the interface, bank and top modules.
package banked_regfile_pkg;

  localparam int XLEN      = 16;
  localparam int PC_IDX    = 7;
  localparam int SP_IDX    = 5;
  localparam int PC_STEP   = 2;
  localparam int SP_STEP   = 2;
  localparam int IE_BIT    = 3;
  localparam int TRAP_NR_W = 4;

  localparam logic [XLEN-1:0] IVEC    = 16'h0004;
  localparam logic [XLEN-1:0] CR_USER = 16'h0008;
  localparam logic [XLEN-1:0] CR_SYS  = 16'h0002;

  typedef enum logic [TRAP_NR_W-1:0] {
    TRAP_NONE       = 4'd0,
    TRAP_UART       = 4'd1,
    TRAP_PAGE_FAULT = 4'd2
  } trap_nr_e;

  function automatic logic [XLEN-1:0] nr_to_reg(
    input logic [TRAP_NR_W-1:0] nr
  );
    return {{(XLEN-TRAP_NR_W){1'b0}}, nr};
  endfunction

endpackage

// File: rtl/banked_regfile_if.sv
// Trap handshake: master raises trap_req/trap_fault/trap_nr or reti,
// slave (the register file) answers with a one-cycle trap_ack.
interface banked_regfile_if;
  import banked_regfile_pkg::*;

  logic                 trap_req;
  logic                 trap_fault;
  logic [TRAP_NR_W-1:0] trap_nr;
  logic                 trap_ack;
  logic                 reti;

  modport master (
    output trap_req, trap_fault, trap_nr, reti,
    input  trap_ack
  );

  modport slave (
    input  trap_req, trap_fault, trap_nr, reti,
    output trap_ack
  );

endinterface

// File: rtl/banked_regfile_regbank.sv
// One register bank: NREGS regs (r0 held at zero) plus its CR.
// Ports: cycle ops gated by active, rewind/enter/set_ie trap hooks.
module banked_regfile_regbank
  import banked_regfile_pkg::*;
#(
  parameter int              NREGS  = 8,
  parameter int              SELW   = $clog2(NREGS),
  parameter logic [XLEN-1:0] CR_RST = CR_USER,
  parameter logic [XLEN-1:0] PC_RST = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         active,
  input  logic                         wr_en,
  input  logic [SELW-1:0]              wr_sel,
  input  logic [XLEN-1:0]              wr_data,
  input  logic                         pc_incr,
  input  logic                         sp_incr,
  input  logic                         sp_decr,
  input  logic                         cr_wr_en,
  input  logic [XLEN-1:0]              cr_wr_data,
  input  logic                         rewind,
  input  logic                         enter,
  input  logic [TRAP_NR_W-1:0]         enter_nr,
  input  logic                         set_ie,
  output logic [NREGS-1:0][XLEN-1:0]   regs_o,
  output logic [XLEN-1:0]              cr_o
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [XLEN-1:0]            cr_q, cr_d;

  always_comb begin
    regs_d = regs_q;
    cr_d   = cr_q;
    if (active) begin
      if (sp_incr && !sp_decr)
        regs_d[SP_IDX] = regs_q[SP_IDX] + XLEN'(SP_STEP);
      else if (sp_decr && !sp_incr)
        regs_d[SP_IDX] = regs_q[SP_IDX] - XLEN'(SP_STEP);
      if (pc_incr)
        regs_d[PC_IDX] = regs_q[PC_IDX] + XLEN'(PC_STEP);
      if (wr_en && wr_sel != '0)
        regs_d[wr_sel] = wr_data;
      if (cr_wr_en)
        cr_d = cr_wr_data;
    end
    // fault rewind lands on top of this cycle's pc/write result
    if (rewind)
      regs_d[PC_IDX] = regs_d[PC_IDX] - XLEN'(PC_STEP);
    if (enter) begin
      regs_d[1]      = nr_to_reg(enter_nr);
      regs_d[PC_IDX] = IVEC;
      cr_d[IE_BIT]   = 1'b0;
    end
    if (set_ie)
      cr_d[IE_BIT] = 1'b1;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q         <= '0;
      regs_q[PC_IDX] <= PC_RST;
      cr_q           <= CR_RST;
    end else begin
      regs_q <= regs_d;
      cr_q   <= cr_d;
    end
  end

  assign regs_o = regs_q;
  assign cr_o   = cr_q;

endmodule

// File: rtl/banked_regfile.sv
// Banked register file: NBANKS banks, trap nesting, RETI, PC/SP stepping.
// Ports: 2 read, 1 write, pc/sp/cr ops, trap if (slave), bank, double_fault.
module banked_regfile
  import banked_regfile_pkg::*;
#(
  parameter int NREGS  = 8,
  parameter int NBANKS = 4,
  parameter int SELW   = $clog2(NREGS),
  parameter int BW     = $clog2(NBANKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SELW-1:0]   rd0_sel,
  output logic [XLEN-1:0]   rd0_data,
  input  logic [SELW-1:0]   rd1_sel,
  output logic [XLEN-1:0]   rd1_data,
  input  logic              wr_en,
  input  logic [SELW-1:0]   wr_sel,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              pc_incr,
  input  logic              sp_incr,
  input  logic              sp_decr,
  input  logic              cr_wr_en,
  input  logic [XLEN-1:0]   cr_wr_data,
  output logic [XLEN-1:0]   cr_out,
  banked_regfile_if.slave   trap,
  output logic [BW-1:0]     bank,
  output logic              double_fault
);

  logic [BW-1:0] bank_q, bank_d;
  logic          trap_ack_q, trap_ack_d;
  logic          df_q, df_d;

  logic [NREGS-1:0][XLEN-1:0] regs_all [NBANKS];
  logic [XLEN-1:0]            cr_all   [NBANKS];
  logic [XLEN-1:0]            cr_cur;

  logic top_bank;
  logic sample;
  logic accept;
  logic df_evt;
  logic do_reti;

  assign cr_cur   = cr_all[bank_q];
  assign top_bank = (bank_q == BW'(NBANKS-1));
  // request is not looked at while the previous ack is still high
  assign sample   = trap.trap_req && !trap.reti && !trap_ack_q;
  assign accept   = sample && !top_bank
                 && (trap.trap_fault || cr_cur[IE_BIT]);
  assign df_evt   = sample && top_bank && trap.trap_fault;
  assign do_reti  = trap.reti && (bank_q != '0);

  always_comb begin
    bank_d = bank_q;
    if (accept)
      bank_d = bank_q + BW'(1);
    else if (do_reti)
      bank_d = bank_q - BW'(1);
    trap_ack_d = accept || df_evt;
    df_d       = df_q || df_evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q     <= '0;
      trap_ack_q <= 1'b0;
      df_q       <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      trap_ack_q <= trap_ack_d;
      df_q       <= df_d;
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic is_cur;
    logic is_next;
    logic is_prev_of_cur;

    assign is_cur         = (bank_q == BW'(b));
    assign is_next        = (b > 0) && (bank_q == BW'(b-1));
    assign is_prev_of_cur = (b < NBANKS-1) && (bank_q == BW'(b+1));

    banked_regfile_regbank #(
      .NREGS  (NREGS),
      .SELW   (SELW),
      .CR_RST ((b == 0) ? CR_USER : CR_SYS),
      .PC_RST ((b == 0) ? '0 : IVEC)
    ) u_bank (
      .clk        (clk),
      .reset      (reset),
      .active     (is_cur),
      .wr_en      (wr_en),
      .wr_sel     (wr_sel),
      .wr_data    (wr_data),
      .pc_incr    (pc_incr),
      .sp_incr    (sp_incr),
      .sp_decr    (sp_decr),
      .cr_wr_en   (cr_wr_en),
      .cr_wr_data (cr_wr_data),
      .rewind     (accept && trap.trap_fault && is_cur),
      .enter      (accept && is_next),
      .enter_nr   (trap.trap_nr),
      .set_ie     (do_reti && !accept && is_prev_of_cur),
      .regs_o     (regs_all[b]),
      .cr_o       (cr_all[b])
    );
  end

  assign rd0_data = (rd0_sel == '0) ? '0
                  : regs_all[bank_q][rd0_sel];
  assign rd1_data = (rd1_sel == '0) ? '0
                  : regs_all[bank_q][rd1_sel];

  assign cr_out        = cr_cur;
  assign trap.trap_ack = trap_ack_q;
  assign bank          = bank_q;
  assign double_fault  = df_q;

endmodule
